// File: rtl/mem_load_unit_pkg.sv
// Shared definitions for the RV32I load unit: funct3 codes, FSM states, size codes.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
// Size codes are shared with the store path's write_length (0 byte, 1 half, 2 word).
package mem_load_unit_pkg;

  localparam logic [2:0] LOAD_LB  = 3'b000;
  localparam logic [2:0] LOAD_LH  = 3'b001;
  localparam logic [2:0] LOAD_LW  = 3'b010;
  localparam logic [2:0] LOAD_LBU = 3'b100;
  localparam logic [2:0] LOAD_LHU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_READ_LO = 2'd1,
    S_READ_HI = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  function automatic logic load_legal(input logic [2:0] f3);
    logic ok;
    case (f3)
      LOAD_LB, LOAD_LH, LOAD_LW, LOAD_LBU, LOAD_LHU: ok = 1'b1;
      default:                                       ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic size_t load_size(input logic [2:0] f3);
    size_t sz;
    case (f3)
      LOAD_LB, LOAD_LBU: sz = SZ_BYTE;
      LOAD_LH, LOAD_LHU: sz = SZ_HALF;
      default:           sz = SZ_WORD;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/mem_load_unit_load_extract.sv
// Selects a byte/half/word from a {hi,lo} little-endian word pair and extends it.
// Latency: purely combinational.
// Backpressure: none.
// Ports: lo_word_i/hi_word_i  words read at the lower/higher address,
//        offset_i             byte offset of the load in lo_word_i,
//        funct3_i             RV32I load funct3, data_o extended result.
module load_extract (
  input  logic [31:0] lo_word_i,
  input  logic [31:0] hi_word_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);
  import mem_load_unit_pkg::*;

  logic [63:0] dword;
  logic [31:0] win;

  assign dword = {hi_word_i, lo_word_i};
  // Little-endian: byte at offset N ends up in bits [7:0] after a shift by 8*N.
  assign win   = 32'(dword >> {offset_i, 3'b000});

  always_comb begin
    data_o = win;
    case (funct3_i)
      LOAD_LB:  data_o = {{24{win[7]}},  win[7:0]};
      LOAD_LBU: data_o = {24'h0,         win[7:0]};
      LOAD_LH:  data_o = {{16{win[15]}}, win[15:0]};
      LOAD_LHU: data_o = {16'h0,         win[15:0]};
      default:  data_o = win;
    endcase
  end

endmodule

// File: rtl/mem_load_unit.sv
// RV32I load unit: word-aligned reads from little-endian data memory, then extract/extend.
// Latency: accept->resp_valid 2 edges (in-word), 3 (split, MISALIGNED_SPLIT_EN), 1 (fault).
// Backpressure: response held stable while resp_ready=0; req_ready high only in IDLE.
// Config macro: MISALIGNED_SPLIT_EN - when defined, word-crossing LH/LW use a second read
//   (READ_HI); when undefined, any non-naturally-aligned LH/LW returns resp_fault.
// Ports: clk/rst (async active-high); req_valid/req_ready/req_addr/req_funct3 request;
//   mem_address/mem_read_data memory read port; resp_valid/resp_ready/resp_data/resp_fault.
module mem_load_unit #(
  parameter int ADDR_WIDTH       = 32,
  parameter bit FAULT_ON_ILLEGAL = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [2:0]            req_funct3,
  output logic [ADDR_WIDTH-1:0] mem_address,
  input  logic [31:0]           mem_read_data,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_data,
  output logic                  resp_fault
);
  import mem_load_unit_pkg::*;

  state_t                state_q, state_d;
  logic [1:0]            off_q, off_d;
  logic [2:0]            f3_q, f3_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           data_q, data_d;
  logic                  fault_q, fault_d;

  logic [2:0]  f3_eff;
  size_t       req_size;
  logic        req_bad;
  logic [31:0] ext_lo, ext_hi, ext_data;

  // With FAULT_ON_ILLEGAL=0 an unsupported funct3 is simply served as LW.
  assign f3_eff   = load_legal(req_funct3) ? req_funct3 : LOAD_LW;
  assign req_size = load_size(f3_eff);

  // Requests answered immediately with a fault, without touching memory.
  always_comb begin
    req_bad = 1'b0;
    if (FAULT_ON_ILLEGAL && !load_legal(req_funct3)) req_bad = 1'b1;
`ifndef MISALIGNED_SPLIT_EN
    if (req_size == SZ_HALF && req_addr[0])          req_bad = 1'b1;
    if (req_size == SZ_WORD && req_addr[1:0] != 2'b00) req_bad = 1'b1;
`endif
  end

`ifdef MISALIGNED_SPLIT_EN
  logic [31:0] lo_q, lo_d;
  size_t       cur_size;
  logic        need_hi;

  assign cur_size = load_size(f3_q);
  // Only accesses that run past byte 3 of the low word need the second read.
  assign need_hi  = (cur_size == SZ_HALF && off_q == 2'd3) ||
                    (cur_size == SZ_WORD && off_q != 2'd0);
  // In READ_LO the low word is still live on the bus; in READ_HI it was captured.
  assign ext_lo   = (state_q == S_READ_HI) ? lo_q : mem_read_data;
  assign ext_hi   = (state_q == S_READ_HI) ? mem_read_data : 32'h0;
`else
  assign ext_lo   = mem_read_data;
  assign ext_hi   = 32'h0;
`endif

  load_extract u_extract (
    .lo_word_i (ext_lo),
    .hi_word_i (ext_hi),
    .offset_i  (off_q),
    .funct3_i  (f3_q),
    .data_o    (ext_data)
  );

  always_comb begin
    state_d = state_q;
    off_d   = off_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    data_d  = data_q;
    fault_d = fault_q;
`ifdef MISALIGNED_SPLIT_EN
    lo_d    = lo_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          off_d = req_addr[1:0];
          f3_d  = f3_eff;
          if (req_bad) begin
            state_d = S_RESP;
            data_d  = 32'h0;
            fault_d = 1'b1;
          end else begin
            state_d = S_READ_LO;
            addr_d  = {req_addr[ADDR_WIDTH-1:2], 2'b00};
          end
        end
      end
      S_READ_LO: begin
`ifdef MISALIGNED_SPLIT_EN
        if (need_hi) begin
          state_d = S_READ_HI;
          lo_d    = mem_read_data;
          addr_d  = addr_q + ADDR_WIDTH'(4);  // wraps modulo 2^ADDR_WIDTH
        end else begin
          state_d = S_RESP;
          data_d  = ext_data;
          fault_d = 1'b0;
        end
`else
        state_d = S_RESP;
        data_d  = ext_data;
        fault_d = 1'b0;
`endif
      end
`ifdef MISALIGNED_SPLIT_EN
      S_READ_HI: begin
        state_d = S_RESP;
        data_d  = ext_data;
        fault_d = 1'b0;
      end
`endif
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      off_q   <= 2'b00;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      data_q  <= 32'h0;
      fault_q <= 1'b0;
`ifdef MISALIGNED_SPLIT_EN
      lo_q    <= 32'h0;
`endif
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      fault_q <= fault_d;
`ifdef MISALIGNED_SPLIT_EN
      lo_q    <= lo_d;
`endif
    end
  end

  assign req_ready   = (state_q == S_IDLE);
  assign resp_valid  = (state_q == S_RESP);
  assign resp_data   = data_q;
  assign resp_fault  = fault_q;
  assign mem_address = addr_q;

endmodule

// File: doc/mem_load_unit.md
Name: mem_load_unit

Overview:
- Read-side initiator for the byte-addressed, little-endian data Memory.
- Accepts RV32I load requests (LB/LH/LW/LBU/LHU) from the execute stage.
- Drives word-aligned reads on the Memory read port, then selects, merges and sign- or zero-extends the returned bytes.
- Returns the result through a valid/ready response handshake; it is the load counterpart of the store path that uses write_length.

Parameters:
- ADDR_WIDTH, 32, width of req_addr and mem_address.
- FAULT_ON_ILLEGAL, 1: 1 = an unsupported funct3 returns resp_fault; 0 = it is treated as LW.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  load request present.
- req_ready  output  1  unit can accept a request; high only in IDLE.
- req_addr  input  ADDR_WIDTH  byte address of the load.
- req_funct3  input  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- mem_address  output  ADDR_WIDTH  word-aligned read address to Memory, low two bits always 0.
- mem_read_data  input  32  Memory combinational read data, little-endian.
- resp_valid  output  1  result available.
- resp_ready  input  1  consumer takes the result.
- resp_data  output  32  extended load result.
- resp_fault  output  1  illegal funct3 or unsupported misalignment; resp_data is 0 when set.

Behaviour:
- Reset values: state IDLE, req_ready=1, mem_address=0, resp_valid=0, resp_data=0, resp_fault=0.
- Reset assertion at any time, including mid-transaction, returns all outputs to these values immediately. Any in-flight load is dropped.
- FSM states: IDLE, READ_LO, READ_HI, RESP.
- IDLE:
  - The request is accepted on a rising edge with req_valid && req_ready.
  - addr, funct3 and offset=addr[1:0] are latched.
  - A legal request moves to READ_LO.
  - An illegal funct3 (FAULT_ON_ILLEGAL=1) moves directly to RESP with fault=1, and no memory read is made.
- READ_LO:
  - mem_address = {addr[ADDR_WIDTH-1:2],2'b00}.
  - mem_read_data is sampled into lo_word at the next edge.
  - The next state is READ_HI if the access crosses a word boundary (LH offset 3, LW offset != 0) and the split feature is enabled; otherwise RESP.
- READ_HI:
  - mem_address = lo word address + 4, wrapping modulo 2^ADDR_WIDTH.
  - mem_read_data is sampled into hi_word; the next state is RESP.
- Extraction:
  - Form the 64-bit value {hi_word, lo_word} and shift it right by 8*offset.
  - Take byte [7:0], half [15:0] or word [31:0].
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
- RESP:
  - resp_valid=1. resp_data and resp_fault are registered and held stable while resp_ready=0.
  - On resp_valid && resp_ready the unit returns to IDLE.
  - A new request is accepted no earlier than the following cycle; there is no same-cycle turnaround.
- Latency from the accept edge: aligned or in-word access gives resp_valid 2 edges later; a split access gives 3 edges later; an illegal funct3 gives 1 edge later.
- mem_address holds its last value outside the READ states.
- Inputs are ignored outside IDLE.

Optional Feature:
- Macro: MISALIGNED_SPLIT_EN.
- Defined:
  - Word-crossing LH and LW are served in two reads (READ_HI is used).
  - Non-crossing misaligned halves (offset 1) are served in one read.
- Undefined:
  - Any access not naturally aligned (LH addr[0]!=0, LW addr[1:0]!=0) skips the memory reads and goes to RESP.
  - It returns resp_fault=1 with resp_data=0.
  - The READ_HI state and its logic are not compiled.

Decomposition:
- Shared package holds:
  - funct3 load constants LOAD_LB/LH/LW/LBU/LHU;
  - FSM state encodings;
  - size encodings matching write_length (0 byte, 1 half, 2 word).
- One combinational sub-module, load_extract:
  - inputs: lo_word, hi_word, offset, funct3;
  - output: 32-bit extended data.
  - It is reusable and unit-testable separately.

Test Plan:
- Preload: word at byte address 4 = 0xABBDADEF, word at address 8 = 0x1234EFDA.
- LB addr 7 -> resp_data 0xFFFFFFAB with resp_valid exactly 2 edges after accept. LBU addr 7 -> 0x000000AB.
- LH addr 6 -> 0xFFFFABBD. LHU addr 4 -> 0x0000ADEF. LW addr 4 -> 0xABBDADEF. mem_address observed as 4 in READ_LO.
- LW addr 6:
  - with MISALIGNED_SPLIT_EN: mem_address 4 then 8, resp_data 0xEFDAABBD, 3-edge latency;
  - without: resp_fault=1, resp_data=0, no read state entered.
- funct3 3'b011 -> resp_fault=1 after 1 edge, req_ready=0 until the response handshake completes.
- LB addr 5 with resp_ready held low 3 cycles -> resp_valid and 0xFFFFFFAD held stable; req_ready returns to 1 the cycle after resp_ready rises.
- rst pulsed during READ_LO/READ_HI -> resp_valid=0, req_ready=1, mem_address=0 immediately; the next LW addr 8 returns 0x1234EFDA.
